// File: rtl/lsu_unaligned_ctrl_pkg.sv
// lsu_unaligned_ctrl_pkg: DM align codes, controller states and registered request layout.
package lsu_unaligned_ctrl_pkg;
  localparam int LSU_ADDR_W = 32;
  localparam int LSU_DATA_W = 32;
  localparam logic [1:0] ALIGN_WORD = 2'b00;
  localparam logic [1:0] ALIGN_HALF = 2'b01;
  localparam logic [1:0] ALIGN_BYTE = 2'b10;
  localparam logic [1:0] ALIGN_RSV  = 2'b11;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_DONE, ST_ERR} lsu_st_e;
  typedef struct packed {
    logic                  we;
    logic [1:0]            align;
    logic                  sign;
    logic [LSU_ADDR_W-1:0] addr;
    logic [LSU_DATA_W-1:0] wd;
    logic [LSU_ADDR_W-1:0] pc;
  } lsu_req_t;
endpackage

// File: rtl/lsu_unaligned_ctrl_beat.sv
// lsu_beat_plan: beat count, split flag and per-beat DM address/align/data for a request.
module lsu_beat_plan
  import lsu_unaligned_ctrl_pkg::*;
(
  input  logic [1:0]            align,
  input  logic [LSU_ADDR_W-1:0] addr,
  input  logic [LSU_DATA_W-1:0] wd,
  input  logic [1:0]            beat,
  output logic [2:0]            n,
  output logic                  split,
  output logic [LSU_ADDR_W-1:0] dm_addr,
  output logic [1:0]            dm_align,
  output logic [LSU_DATA_W-1:0] dm_wd
);
  always_comb begin
    split    = (align == ALIGN_HALF && addr[0]) || (align == ALIGN_WORD && addr[1:0] != 2'b00);
    n        = !split ? 3'd1 : align == ALIGN_HALF ? 3'd2 : 3'd4;
    dm_addr  = split ? addr + {{(LSU_ADDR_W-2){1'b0}}, beat} : addr;
    dm_align = split ? ALIGN_BYTE : align;
    dm_wd    = split ? {24'b0, wd[{beat, 3'b000} +: 8]} : wd;
  end
endmodule

// File: rtl/lsu_unaligned_ctrl.sv
// lsu_unaligned_ctrl: DM initiator that splits misaligned half/word accesses into byte beats.
module lsu_unaligned_ctrl
  import lsu_unaligned_ctrl_pkg::*;
#(
  parameter int ADDR_W = LSU_ADDR_W,
  parameter int DATA_W = LSU_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_align,
  input  logic              req_sign,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wd,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rd,
  output logic              resp_err,
  output logic [ADDR_W-1:0] dm_pc,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_we,
  output logic [1:0]        dm_align,
  output logic              dm_sign,
  output logic [DATA_W-1:0] dm_wd,
  input  logic [DATA_W-1:0] dm_rd
);
  lsu_st_e state_q, state_d;
  lsu_req_t req_q, req_d;
  logic [1:0] beat_q, beat_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [2:0] n;
  logic split;
  logic [ADDR_W-1:0] p_addr;
  logic [1:0] p_align;
  logic [DATA_W-1:0] p_wd;
  lsu_beat_plan u_plan (
    .align(req_q.align), .addr(req_q.addr), .wd(req_q.wd), .beat(beat_q),
    .n(n), .split(split), .dm_addr(p_addr), .dm_align(p_align), .dm_wd(p_wd)
  );
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    beat_d     = beat_q;
    acc_d      = acc_q;
    req_ready  = state_q == ST_IDLE;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rd    = '0;
    dm_pc      = '0;
    dm_addr    = '0;
    dm_we      = 1'b0;
    dm_align   = 2'b00;
    dm_sign    = 1'b0;
    dm_wd      = '0;
    case (state_q)
      ST_IDLE: if (req_valid) begin
        req_d   = '{we: req_we, align: req_align, sign: req_sign, addr: req_addr, wd: req_wd, pc: req_pc};
        beat_d  = 2'd0;
        acc_d   = '0;
        state_d = req_align == ALIGN_RSV ? ST_ERR : ST_ACCESS;
      end
      ST_ACCESS: begin
        dm_pc    = req_q.pc;
        dm_addr  = p_addr;
        dm_we    = req_q.we & ~rst;
        dm_align = p_align;
        dm_sign  = split ? 1'b0 : req_q.sign;
        dm_wd    = p_wd;
        if (!req_q.we && split) acc_d[{beat_q, 3'b000} +: 8] = dm_rd[7:0];
        else if (!req_q.we) acc_d = dm_rd;
        beat_d  = beat_q + 2'd1;
        state_d = {1'b0, beat_q} == n - 3'd1 ? ST_DONE : ST_ACCESS;
      end
      ST_DONE: begin
        resp_valid = ~rst;
        resp_rd    = req_q.we ? '0 :
                     (split && req_q.align == ALIGN_HALF) ? {{16{acc_q[15] & req_q.sign}}, acc_q[15:0]} : acc_q;
        state_d    = ST_IDLE;
      end
      default: begin
        resp_valid = ~rst;
        resp_err   = ~rst;
        state_d    = ST_IDLE;
      end
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      beat_q  <= 2'd0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      beat_q  <= beat_d;
      acc_q   <= acc_d;
    end
  end
endmodule
